// File: rtl/frac_pwm_gen_pkg.sv
// Shared constants and helpers for the fractional-N PWM generator.
package frac_pwm_gen_pkg;

    localparam int unsigned DefWidth  = 17;
    localparam int unsigned DefFrac   = 4;
    localparam int          MinPeriod = 2;

    // Saturate a signed period request into [MinPeriod, p_max].
    function automatic int clamp_period(input int p_raw, input int p_max);
        if (p_raw < MinPeriod) begin
            return MinPeriod;
        end
        if (p_raw > p_max) begin
            return p_max;
        end
        return p_raw;
    endfunction

endpackage

// File: rtl/frac_pwm_gen_accum.sv
// First-order sigma-delta accumulator over the fractional bits of the period trim.
module frac_accum
    import frac_pwm_gen_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned FRAC  = DefFrac
) (
    input  logic                    CLK1,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        mf,
    input  logic                    load,
    output logic signed [WIDTH-1:0] int_part,
    output logic                    carry
);

    logic [FRAC-1:0] acc;
    logic [FRAC:0]   sum;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, mf[FRAC-1:0]};
        carry    = sum[FRAC];
        // Arithmetic shift floors negative trims, so the fraction bits stay non-negative.
        int_part = $signed(mf) >>> FRAC;
    end

    always_ff @(posedge CLK1 or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= sum[FRAC-1:0];
        end
    end

endmodule

// File: rtl/frac_pwm_gen.sv
// Fractional-N PWM divider: period N + mf/2^FRAC clocks, high for the first No clocks.
module frac_pwm_gen
    import frac_pwm_gen_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned FRAC  = DefFrac
) (
    input  logic             CLK1,
    input  logic             rst,
    input  logic [WIDTH-1:0] No,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] mf,
    output logic [WIDTH-1:0] count,
    output logic             q_out,
    output logic             tc
);

    localparam int PMax = int'((64'd1 << WIDTH) - 64'd1);

    logic [WIDTH-1:0]        per_r;
    logic [WIDTH-1:0]        no_r;
    logic [WIDTH-1:0]        count_next;
    logic [WIDTH-1:0]        per_next;
    logic [WIDTH-1:0]        no_next;
    logic [WIDTH-1:0]        per_calc;
    logic signed [WIDTH+1:0] p_raw;
    logic signed [WIDTH-1:0] int_part;
    logic                    carry;
    logic                    wrap;

    frac_accum #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_accum (
        .CLK1     (CLK1),
        .rst      (rst),
        .mf       (mf),
        .load     (wrap),
        .int_part (int_part),
        .carry    (carry)
    );

    always_comb begin
        // Two guard bits keep the sum free of overflow before clamping.
        p_raw    = $signed({2'b00, N})
                 + $signed({{2{int_part[WIDTH-1]}}, int_part})
                 + $signed((WIDTH + 2)'(carry));
        per_calc = WIDTH'(clamp_period(int'(p_raw), PMax));

        // per_r == 0 only right after reset and forces the first reload.
        wrap = (per_r == '0) || (count >= per_r - WIDTH'(1));

        count_next = count + WIDTH'(1);
        per_next   = per_r;
        no_next    = no_r;
        if (wrap) begin
            count_next = '0;
            per_next   = per_calc;
            no_next    = No;
        end
    end

    always_ff @(posedge CLK1 or posedge rst) begin
        if (rst) begin
            count <= '0;
            per_r <= '0;
            no_r  <= '0;
            q_out <= 1'b0;
            tc    <= 1'b0;
        end else begin
            count <= count_next;
            per_r <= per_next;
            no_r  <= no_next;
            q_out <= (count_next < no_next);
            tc    <= (count_next == per_next - WIDTH'(1));
        end
    end

endmodule

// File: tb/tb_frac_pwm_gen.sv
// Self-checking bench: period/high-time scoreboard driven from a vector table plus corner sequences.
module tb_frac_pwm_gen;

    localparam int W = 17;

    typedef struct {
        int n;
        int mf;
        int no;
        int nper;
        int p0;
        int p1;
        int p2;
        int p3;
    } vec_t;

    typedef struct {
        int len;
        int hi;
    } exp_t;

    logic         CLK1;
    logic         rst;
    logic [W-1:0] No;
    logic [W-1:0] N;
    logic [W-1:0] mf;
    logic [W-1:0] count;
    logic         q_out;
    logic         tc;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   run_len = 0;
    int   run_hi  = 0;

    frac_pwm_gen #(
        .WIDTH (W),
        .FRAC  (4)
    ) dut (
        .CLK1  (CLK1),
        .rst   (rst),
        .No    (No),
        .N     (N),
        .mf    (mf),
        .count (count),
        .q_out (q_out),
        .tc    (tc)
    );

    initial begin
        CLK1 = 1'b0;
        forever #5 CLK1 = ~CLK1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Measures each period from count==0 up to the tc cycle and scores it.
    always @(negedge CLK1) begin
        exp_t e;
        if (count == '0) begin
            run_len = 1;
            run_hi  = int'(q_out);
        end else begin
            run_len++;
            run_hi += int'(q_out);
        end
        if (tc && sb.size() > 0) begin
            e = sb.pop_front();
            check("period_len", run_len, e.len);
            check("high_time", run_hi, e.hi);
            check("count_at_tc", int'(count), e.len - 1);
        end
    end

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic push_exp(input int len, input int no);
        exp_t e;
        e.len = len;
        e.hi  = min2(no, len);
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (sb.size() > 0 && c < budget) begin
            @(negedge CLK1);
            c++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic enter_reset();
        @(negedge CLK1);
        rst = 1'b1;
        #1;
    endtask

    task automatic wait_count(input int target);
        int c = 0;
        while (int'(count) != target && c < 1000) begin
            @(negedge CLK1);
            c++;
        end
        check("reach_count", int'(count), target);
    endtask

    vec_t vecs[10];

    initial begin
        int pp[4];
        int cyc;
        int tcs;

        vecs[0] = '{n: 68750, mf: 0,   no: 34375, nper: 1, p0: 68750, p1: 68750, p2: 68750, p3: 68750};
        vecs[1] = '{n: 10,    mf: 8,   no: 5,     nper: 8, p0: 10, p1: 11, p2: 10, p3: 11};
        vecs[2] = '{n: 10,    mf: -16, no: 5,     nper: 6, p0: 9,  p1: 9,  p2: 9,  p3: 9};
        vecs[3] = '{n: 10,    mf: -8,  no: 5,     nper: 8, p0: 9,  p1: 10, p2: 9,  p3: 10};
        vecs[4] = '{n: 10,    mf: 0,   no: 0,     nper: 4, p0: 10, p1: 10, p2: 10, p3: 10};
        vecs[5] = '{n: 10,    mf: 0,   no: 15,    nper: 4, p0: 10, p1: 10, p2: 10, p3: 10};
        vecs[6] = '{n: 0,     mf: 0,   no: 1,     nper: 6, p0: 2,  p1: 2,  p2: 2,  p3: 2};
        vecs[7] = '{n: 20,    mf: 4,   no: 3,     nper: 8, p0: 20, p1: 20, p2: 20, p3: 21};
        vecs[8] = '{n: 10,    mf: -12, no: 5,     nper: 8, p0: 9,  p1: 9,  p2: 9,  p3: 10};
        vecs[9] = '{n: 1,     mf: -32, no: 1,     nper: 4, p0: 2,  p1: 2,  p2: 2,  p3: 2};

        rst = 1'b0;
        N   = W'(123);
        mf  = W'(7);
        No  = W'(3);
        #1 rst = 1'b1;
        repeat (2) @(negedge CLK1);
        check("reset_count", int'(count), 0);
        check("reset_q_out", int'(q_out), 0);
        check("reset_tc", int'(tc), 0);

        foreach (vecs[i]) begin
            enter_reset();
            N  = W'(vecs[i].n);
            mf = W'(vecs[i].mf);
            No = W'(vecs[i].no);
            pp[0] = vecs[i].p0;
            pp[1] = vecs[i].p1;
            pp[2] = vecs[i].p2;
            pp[3] = vecs[i].p3;
            for (int k = 0; k < vecs[i].nper; k++) begin
                push_exp(pp[k % 4], vecs[i].no);
            end
            @(negedge CLK1);
            rst = 1'b0;
            wait_drain(vecs[i].n + 70000);
        end

        // 1000 periods of 10.5 clocks on average.
        enter_reset();
        N  = W'(10);
        mf = W'(8);
        No = W'(5);
        @(negedge CLK1);
        rst = 1'b0;
        @(posedge CLK1);
        cyc = 0;
        tcs = 0;
        while (tcs < 1000 && cyc < 20000) begin
            @(negedge CLK1);
            cyc++;
            if (tc) tcs++;
        end
        check("span_1000_periods", cyc, 10500);

        // Mid-period change of N only takes effect at the next wrap.
        enter_reset();
        N  = W'(100);
        mf = W'(0);
        No = W'(10);
        push_exp(100, 10);
        push_exp(50, 10);
        @(negedge CLK1);
        rst = 1'b0;
        wait_count(20);
        N = W'(50);
        wait_drain(400);

        // Asynchronous reset mid-period while q_out is high, then reload on release.
        enter_reset();
        N  = W'(100);
        No = W'(60);
        @(negedge CLK1);
        rst = 1'b0;
        wait_count(40);
        check("pre_reset_q_out", int'(q_out), 1);
        #1 rst = 1'b1;
        #1;
        check("async_count", int'(count), 0);
        check("async_q_out", int'(q_out), 0);
        check("async_tc", int'(tc), 0);
        N  = W'(30);
        No = W'(7);
        push_exp(30, 7);
        @(negedge CLK1);
        rst = 1'b0;
        wait_drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
